// File: rtl/cdr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdr_pkg
//  Description : Shared constants and types for the bang-bang chip clock/data
//                recovery loop (ZigBee O-QPSK/MSK receiver, 2 Mchip/s).
//  Revision    : 1.0  initial release
// ============================================================================
package cdr_pkg;

    localparam int DEF_CHIP_CLKS   = 25;  // 50 MHz cycles per 500 ns chip
    localparam int DEF_SYNC_STAGES = 2;   // i_phase synchronizer depth
    localparam int DEF_LOCK_TOL    = 2;   // |e| bound for a "good" edge
    localparam int DEF_LOCK_EDGES  = 8;   // good edges in a row to declare lock

    typedef logic signed [4:0] phase_err_t;
    typedef logic        [4:0] cnt_t;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_TRACKING = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/cdr_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : cdr_edge_det
//  Description : Multi-flop synchronizer for the asynchronous phase decision
//                followed by a one-cycle XOR transition detector.
//  Revision    : 1.0  initial release
// ============================================================================
module cdr_edge_det
    import cdr_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_phase,
    output logic o_ps,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ps_d;

    // Shift i_phase through the synchronizer and keep one delayed copy of ps
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync <= '0;
            r_ps_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_phase};
            r_ps_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_ps   = r_sync[SYNC_STAGES-1];
    assign o_edge = r_sync[SYNC_STAGES-1] ^ r_ps_d;

endmodule
`default_nettype wire

// File: rtl/cdr.sv
`default_nettype none
// ============================================================================
//  Module      : cdr
//  Description : Bang-bang chip clock/data recovery. A modulo-CHIP_CLKS phase
//                counter is nudged one cycle per accepted transition, the
//                synchronized chip is sampled mid-chip, and a lock FSM counts
//                consecutive small-error transitions.
//  Revision    : 1.0  initial release
// ============================================================================
module cdr
    import cdr_pkg::*;
#(
    parameter int CHIP_CLKS   = DEF_CHIP_CLKS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_TOL    = DEF_LOCK_TOL,
    parameter int LOCK_EDGES  = DEF_LOCK_EDGES
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_phase,
    input  logic       i_flag,
    output logic       o_data,
    output logic       o_valid,
    output logic       o_lock,
    output logic [4:0] o_phase_err
);

    localparam int HALF_CHIP = CHIP_CLKS / 2;
    localparam int LC_W      = $clog2(LOCK_EDGES + 1);

    typedef logic [LC_W-1:0] lcnt_t;

    logic        w_ps;
    logic        w_edge;
    cnt_t        r_cnt;
    cnt_t        w_cnt_inc1;
    cnt_t        w_cnt_inc2;
    cnt_t        w_cnt_nxt;
    phase_err_t  w_err;
    phase_err_t  r_perr;
    logic        w_accept;
    logic        w_good;
    logic        w_cross;
    logic        r_data;
    logic        r_valid;
    lcnt_t       r_lock_cnt;
    lock_state_t r_state;
    lock_state_t w_state_nxt;

    cdr_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_det (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_phase (i_phase),
        .o_ps    (w_ps),
        .o_edge  (w_edge)
    );

    // Phase error of the current counter position and the resulting next count
    always_comb begin
        w_err = phase_err_t'(r_cnt);
        if (r_cnt > cnt_t'(HALF_CHIP)) begin
            w_err = phase_err_t'(int'(r_cnt) - CHIP_CLKS);
        end
        w_accept   = w_edge & ~i_flag;
        w_good     = (w_err <= phase_err_t'(LOCK_TOL)) && (w_err >= -phase_err_t'(LOCK_TOL));
        w_cnt_inc1 = (r_cnt == cnt_t'(CHIP_CLKS - 1)) ? '0 : r_cnt + cnt_t'(1);
        w_cnt_inc2 = (r_cnt >= cnt_t'(CHIP_CLKS - 2)) ? r_cnt - cnt_t'(CHIP_CLKS - 2)
                                                       : r_cnt + cnt_t'(2);
        w_cnt_nxt  = w_cnt_inc1;
        if (w_accept && !w_err[4] && (w_err != '0)) begin
            w_cnt_nxt = r_cnt;          // counter ahead: lose one cycle
        end else if (w_accept && w_err[4]) begin
            w_cnt_nxt = w_cnt_inc2;     // counter behind: gain one cycle
        end
        // Fire once when the count leaves the lower half, whatever step it took
        w_cross = (r_cnt <= cnt_t'(HALF_CHIP)) && (w_cnt_nxt > cnt_t'(HALF_CHIP));
    end

    // Phase counter register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Mid-chip sampler
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_data  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_cross;
            if (w_cross) begin
                r_data <= w_ps;
            end
        end
    end

    // Error report and consecutive-good-edge counter, updated on accepted edges only
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_perr     <= '0;
            r_lock_cnt <= '0;
        end else if (w_accept) begin
            r_perr <= w_err;
            if (!w_good) begin
                r_lock_cnt <= '0;
            end else if (r_lock_cnt != lcnt_t'(LOCK_EDGES)) begin
                r_lock_cnt <= r_lock_cnt + lcnt_t'(1);
            end
        end
    end

    // Lock state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock next state: a bad edge drops lock at once, otherwise follow lock_cnt
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept && !w_good) begin
            w_state_nxt = ST_UNLOCKED;
        end else if (r_lock_cnt == lcnt_t'(LOCK_EDGES)) begin
            w_state_nxt = ST_LOCKED;
        end else if (r_lock_cnt == '0) begin
            w_state_nxt = ST_UNLOCKED;
        end else begin
            w_state_nxt = ST_TRACKING;
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_lock      = (r_state == ST_LOCKED);
    assign o_phase_err = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_cdr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdr
//  Description : Directed self-checking bench for the cdr loop. Chip streams
//                are built from a chip table with a per-scenario offset;
//                expected sample times, errors and lock cycles are tabulated.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cdr;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_phase;
    logic       i_flag;
    logic       o_data;
    logic       o_valid;
    logic       o_lock;
    logic [4:0] o_phase_err;

    int n_cmp = 0;
    int n_bad = 0;

    bit                chips    [0:15];
    logic signed [4:0] perr_log [0:511];
    logic              lock_log [0:511];
    int                vt[$];
    bit                vd[$];

    always #5 clk = ~clk;

    cdr u_dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_phase     (i_phase),
        .i_flag      (i_flag),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_lock      (o_lock),
        .o_phase_err (o_phase_err)
    );

    // Chip value on i_phase as seen by posedge j after reset release
    function automatic bit phase_at(input int j, input int off, input int jumpc);
        int c;
        c = 0;
        for (int k = 1; k < 16; k++) begin
            int b;
            b = 24 + off + 25 * (k - 1) + ((k == jumpc) ? 12 : 0);
            if (j >= b) c = k;
        end
        return chips[c];
    endfunction

    task automatic set_alt();
        for (int k = 0; k < 16; k++) chips[k] = k[0];
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        i_rst  = 1'b0;
        i_flag = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_phase = ~i_phase;
            @(posedge clk); #1;
        end
        i_phase = 1'b0;
        i_rst   = 1'b1;
    endtask

    task automatic run_scn(input int off, input int ncyc, input int jumpc, input bit flag_en);
        vt.delete();
        vd.delete();
        for (int j = 1; j <= ncyc; j++) begin
            i_phase = phase_at(j, off, jumpc);
            i_flag  = flag_en && (j >= 50) && (((j - 1) % 5) == 0);
            @(posedge clk); #1;
            perr_log[j] = o_phase_err;
            lock_log[j] = o_lock;
            if (o_valid === 1'b1) begin
                vt.push_back(j);
                vd.push_back(o_data);
            end
        end
        i_flag = 1'b0;
    endtask

    task automatic test_aligned();
        set_alt();
        apply_reset();
        run_scn(0, 215, 0, 1'b0);
        n_cmp++;
        if (vt.size() !== 9) begin
            n_bad++; $display("FAIL aligned_valid_count: got %0d expected 9", vt.size());
        end
        for (int i = 0; i < 9; i++) begin
            int t; bit d;
            t = (i < vt.size()) ? vt[i] : -1;
            d = (i < vd.size()) ? vd[i] : 1'b0;
            n_cmp++;
            if (t !== 13 + 25 * i) begin
                n_bad++; $display("FAIL aligned_valid_t[%0d]: got %0d expected %0d", i, t, 13 + 25 * i);
            end
            n_cmp++;
            if (d !== chips[i]) begin
                n_bad++; $display("FAIL aligned_data[%0d]: got %0d expected %0d", i, d, chips[i]);
            end
        end
        n_cmp++;
        if (lock_log[201] !== 1'b0) begin
            n_bad++; $display("FAIL aligned_lock_201: got %0d expected 0", lock_log[201]);
        end
        n_cmp++;
        if (lock_log[202] !== 1'b1) begin
            n_bad++; $display("FAIL aligned_lock_202: got %0d expected 1", lock_log[202]);
        end
        n_cmp++;
        if (int'(perr_log[215]) !== 0) begin
            n_bad++; $display("FAIL aligned_perr: got %0d expected 0", perr_log[215]);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_cmp++;
        if (o_lock !== 1'b1) begin
            n_bad++; $display("FAIL reset_pre_lock: got %0d expected 1", o_lock);
        end
        i_rst = 1'b0;
        #1;
        n_cmp++;
        if ({o_data, o_valid, o_lock, o_phase_err} !== 8'h00) begin
            n_bad++; $display("FAIL reset_async: got %b expected 00000000",
                              {o_data, o_valid, o_lock, o_phase_err});
        end
        for (int k = 0; k < 2; k++) begin
            i_phase = ~i_phase;
            @(posedge clk); #1;
            n_cmp++;
            if ({o_data, o_valid, o_lock, o_phase_err} !== 8'h00) begin
                n_bad++; $display("FAIL reset_hold[%0d]: got %b expected 00000000",
                                  k, {o_data, o_valid, o_lock, o_phase_err});
            end
        end
        i_phase = 1'b0;
        i_rst   = 1'b1;
        run_scn(0, 40, 0, 1'b0);
        n_cmp++;
        if (vt.size() !== 2) begin
            n_bad++; $display("FAIL reset_valid_count: got %0d expected 2", vt.size());
        end
        n_cmp++;
        if (((vt.size() > 0) ? vt[0] : -1) !== 13) begin
            n_bad++; $display("FAIL reset_first_valid: got %0d expected 13", (vt.size() > 0) ? vt[0] : -1);
        end
    endtask

    task automatic test_offset_pos();
        int exp_t[11] = '{13, 39, 65, 91, 117, 143, 168, 193, 218, 243, 268};
        int exp_e[6]  = '{5, 4, 3, 2, 1, 0};
        set_alt();
        apply_reset();
        run_scn(5, 290, 0, 1'b0);
        n_cmp++;
        if (vt.size() !== 11) begin
            n_bad++; $display("FAIL pos_valid_count: got %0d expected 11", vt.size());
        end
        for (int i = 0; i < 11; i++) begin
            int t; bit d;
            t = (i < vt.size()) ? vt[i] : -1;
            d = (i < vd.size()) ? vd[i] : 1'b0;
            n_cmp++;
            if (t !== exp_t[i]) begin
                n_bad++; $display("FAIL pos_valid_t[%0d]: got %0d expected %0d", i, t, exp_t[i]);
            end
            n_cmp++;
            if (d !== chips[i]) begin
                n_bad++; $display("FAIL pos_data[%0d]: got %0d expected %0d", i, d, chips[i]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (int'(perr_log[31 + 25 * k]) !== exp_e[k]) begin
                n_bad++; $display("FAIL pos_perr[%0d]: got %0d expected %0d", k, perr_log[31 + 25 * k], exp_e[k]);
            end
        end
        n_cmp++;
        if (lock_log[281] !== 1'b0) begin
            n_bad++; $display("FAIL pos_lock_281: got %0d expected 0", lock_log[281]);
        end
        n_cmp++;
        if (lock_log[282] !== 1'b1) begin
            n_bad++; $display("FAIL pos_lock_282: got %0d expected 1", lock_log[282]);
        end
    endtask

    task automatic test_offset_neg();
        int exp_t[11] = '{13, 37, 61, 85, 109, 133, 158, 183, 208, 233, 258};
        int exp_e[6]  = '{-5, -4, -3, -2, -1, 0};
        set_alt();
        apply_reset();
        run_scn(-5, 280, 0, 1'b0);
        n_cmp++;
        if (vt.size() !== 11) begin
            n_bad++; $display("FAIL neg_valid_count: got %0d expected 11", vt.size());
        end
        for (int i = 0; i < 11; i++) begin
            int t; bit d;
            t = (i < vt.size()) ? vt[i] : -1;
            d = (i < vd.size()) ? vd[i] : 1'b0;
            n_cmp++;
            if (t !== exp_t[i]) begin
                n_bad++; $display("FAIL neg_valid_t[%0d]: got %0d expected %0d", i, t, exp_t[i]);
            end
            n_cmp++;
            if (d !== chips[i]) begin
                n_bad++; $display("FAIL neg_data[%0d]: got %0d expected %0d", i, d, chips[i]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (int'(perr_log[21 + 25 * k]) !== exp_e[k]) begin
                n_bad++; $display("FAIL neg_perr[%0d]: got %0d expected %0d", k, perr_log[21 + 25 * k], exp_e[k]);
            end
        end
        n_cmp++;
        if (lock_log[271] !== 1'b0) begin
            n_bad++; $display("FAIL neg_lock_271: got %0d expected 0", lock_log[271]);
        end
        n_cmp++;
        if (lock_log[272] !== 1'b1) begin
            n_bad++; $display("FAIL neg_lock_272: got %0d expected 1", lock_log[272]);
        end
    endtask

    task automatic test_flag();
        int exp_t[12] = '{13, 39, 64, 89, 114, 139, 164, 189, 214, 239, 264, 289};
        int n_lock;
        set_alt();
        apply_reset();
        run_scn(5, 300, 0, 1'b1);
        n_cmp++;
        if (vt.size() !== 12) begin
            n_bad++; $display("FAIL flag_valid_count: got %0d expected 12", vt.size());
        end
        for (int i = 0; i < 12; i++) begin
            int t; bit d;
            t = (i < vt.size()) ? vt[i] : -1;
            d = (i < vd.size()) ? vd[i] : 1'b0;
            n_cmp++;
            if (t !== exp_t[i]) begin
                n_bad++; $display("FAIL flag_valid_t[%0d]: got %0d expected %0d", i, t, exp_t[i]);
            end
            n_cmp++;
            if (d !== chips[i]) begin
                n_bad++; $display("FAIL flag_data[%0d]: got %0d expected %0d", i, d, chips[i]);
            end
        end
        n_cmp++;
        if (int'(perr_log[31]) !== 5) begin
            n_bad++; $display("FAIL flag_perr_first: got %0d expected 5", perr_log[31]);
        end
        n_cmp++;
        if (int'(perr_log[300]) !== 5) begin
            n_bad++; $display("FAIL flag_perr_frozen: got %0d expected 5", perr_log[300]);
        end
        n_lock = 0;
        for (int j = 1; j <= 300; j++) if (lock_log[j] !== 1'b0) n_lock++;
        n_cmp++;
        if (n_lock !== 0) begin
            n_bad++; $display("FAIL flag_lock_cycles: got %0d expected 0", n_lock);
        end
    endtask

    task automatic test_lock_loss();
        set_alt();
        apply_reset();
        run_scn(0, 300, 10, 1'b0);
        n_cmp++;
        if (vt.size() !== 12) begin
            n_bad++; $display("FAIL loss_valid_count: got %0d expected 12", vt.size());
        end
        for (int i = 0; i < 12; i++) begin
            int t, et; bit d;
            et = (i < 10) ? (13 + 25 * i) : ((i == 10) ? 264 : 288);
            t  = (i < vt.size()) ? vt[i] : -1;
            d  = (i < vd.size()) ? vd[i] : 1'b0;
            n_cmp++;
            if (t !== et) begin
                n_bad++; $display("FAIL loss_valid_t[%0d]: got %0d expected %0d", i, t, et);
            end
            n_cmp++;
            if (d !== chips[i]) begin
                n_bad++; $display("FAIL loss_data[%0d]: got %0d expected %0d", i, d, chips[i]);
            end
        end
        n_cmp++;
        if (lock_log[262] !== 1'b1) begin
            n_bad++; $display("FAIL loss_lock_262: got %0d expected 1", lock_log[262]);
        end
        n_cmp++;
        if (lock_log[263] !== 1'b0) begin
            n_bad++; $display("FAIL loss_lock_263: got %0d expected 0", lock_log[263]);
        end
        n_cmp++;
        if (int'(perr_log[263]) !== 12) begin
            n_bad++; $display("FAIL loss_perr_jump: got %0d expected 12", perr_log[263]);
        end
        n_cmp++;
        if (int'(perr_log[276]) !== -1) begin
            n_bad++; $display("FAIL loss_perr_next: got %0d expected -1", perr_log[276]);
        end
        n_cmp++;
        if (lock_log[300] !== 1'b0) begin
            n_bad++; $display("FAIL loss_lock_300: got %0d expected 0", lock_log[300]);
        end
    endtask

    task automatic test_equal_run();
        bit pat[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        set_alt();
        for (int k = 0; k < 8; k++) chips[k] = pat[k];
        apply_reset();
        run_scn(0, 190, 0, 1'b0);
        n_cmp++;
        if (vt.size() !== 8) begin
            n_bad++; $display("FAIL run_valid_count: got %0d expected 8", vt.size());
        end
        for (int i = 0; i < 8; i++) begin
            int t; bit d;
            t = (i < vt.size()) ? vt[i] : -1;
            d = (i < vd.size()) ? vd[i] : 1'b0;
            n_cmp++;
            if (t !== 13 + 25 * i) begin
                n_bad++; $display("FAIL run_valid_t[%0d]: got %0d expected %0d", i, t, 13 + 25 * i);
            end
            n_cmp++;
            if (d !== pat[i]) begin
                n_bad++; $display("FAIL run_data[%0d]: got %0d expected %0d", i, d, pat[i]);
            end
        end
        n_cmp++;
        if (int'(perr_log[190]) !== 0) begin
            n_bad++; $display("FAIL run_perr: got %0d expected 0", perr_log[190]);
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_phase = 1'b0;
        i_flag  = 1'b0;
        test_aligned();
        test_reset();
        test_offset_pos();
        test_offset_neg();
        test_flag();
        test_lock_loss();
        test_equal_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
